// File: rtl/pmem_burst_adapter_pkg.sv
// Shared types and geometry for the cache-to-memory burst adapter.
//
// Contents:
//   adstate_t  adapter FSM states (idle, read burst, write burst, done pulse)
//   LINE_W     cache line width in bits
//   BEAT_W     memory burst beat width in bits
//   BEATS      beats per line (LINE_W / BEAT_W)
//   OFFSET_W   byte-offset bits inside one line (ignored in line addresses)
package pmem_burst_adapter_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = LINE_W / BEAT_W;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    A_IDLE,
    A_RD,
    A_WR,
    A_DONE
  } adstate_t;

endpackage

// File: rtl/pmem_burst_adapter.sv
// Converts one cache line read or write into a burst of BEAT_W-bit beats on
// the memory port and pulses pmem_resp for one cycle when the burst is done.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   pmem_address    line address from the cache (offset bits ignored)
//   pmem_read       line read request, held by the cache until pmem_resp
//   pmem_write      line write request, held by the cache until pmem_resp
//   pmem_wdata      line to write
//   pmem_rdata      assembled line, valid while pmem_resp is high
//   pmem_resp       one-cycle completion pulse
//   burst_address   line-aligned address, constant for the whole burst
//   burst_read      read burst in progress
//   burst_write     write burst in progress
//   burst_wdata     current write beat
//   burst_rdata     returned read beat, valid while burst_resp is high
//   burst_resp      memory accepted / returned the current beat
module pmem_burst_adapter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = pmem_burst_adapter_pkg::LINE_W,
  parameter int BEAT_W = pmem_burst_adapter_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic [ADDR_W-1:0] burst_address,
  output logic              burst_read,
  output logic              burst_write,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp
);

  localparam int NUM_BEATS  = LINE_W / BEAT_W;
  localparam int BEAT_CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  import pmem_burst_adapter_pkg::*;

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(NUM_BEATS - 1);

  adstate_t                       state;
  adstate_t                       next_state;
  logic [BEAT_CNT_W-1:0]          beat;
  logic [LINE_W-1:0]              line;
  logic [ADDR_W-1:OFFSET_W]       line_addr;
  logic                           addr_offset_unused;

  // Byte-offset bits of the request never reach memory; bursts are line aligned.
  assign addr_offset_unused = ^pmem_address[OFFSET_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= A_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode. Write beats read because a dirty line
  // must be written back before the fill that replaces it.
  always_comb begin
    next_state  = state;
    burst_read  = 1'b0;
    burst_write = 1'b0;
    pmem_resp   = 1'b0;
    burst_wdata = '0;
    case (state)
      A_IDLE: begin
        if (pmem_write) begin
          next_state = A_WR;
        end else if (pmem_read) begin
          next_state = A_RD;
        end
      end
      A_RD: begin
        burst_read = 1'b1;
        if (burst_resp && beat == LAST_BEAT) begin
          next_state = A_DONE;
        end
      end
      A_WR: begin
        burst_write = 1'b1;
        burst_wdata = line[int'(beat) * BEAT_W +: BEAT_W];
        if (burst_resp && beat == LAST_BEAT) begin
          next_state = A_DONE;
        end
      end
      A_DONE: begin
        pmem_resp  = 1'b1;
        next_state = A_IDLE;
      end
      default: next_state = A_IDLE;
    endcase
  end

  // Address/line capture and beat counting. The address is latched only in
  // IDLE so changes on pmem_address during a burst are ignored. The counter
  // wraps to zero on the last beat, ready for the next burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat      <= '0;
      line      <= '0;
      line_addr <= '0;
    end else begin
      case (state)
        A_IDLE: begin
          if (pmem_write) begin
            line_addr <= pmem_address[ADDR_W-1:OFFSET_W];
            line      <= pmem_wdata;
          end else if (pmem_read) begin
            line_addr <= pmem_address[ADDR_W-1:OFFSET_W];
          end
        end
        A_RD: begin
          if (burst_resp) begin
            line[int'(beat) * BEAT_W +: BEAT_W] <= burst_rdata;
            beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
          end
        end
        A_WR: begin
          if (burst_resp) begin
            beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign burst_address = {line_addr, {OFFSET_W{1'b0}}};
  assign pmem_rdata    = line;

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Self-checking bench for pmem_burst_adapter: directed scenarios plus
// randomized line reads/writes checked against a line-level model
// (aligned address, beat slices of a 256-bit line).
module tb_pmem_burst_adapter;

  logic         clk;
  logic         rst_n;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int tests_run;
  int tests_failed;

  pmem_burst_adapter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pmem_address  (pmem_address),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value with the bench's expectation.
  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the memory-side response for one cycle and advance.
  task automatic applyStimulus(input logic resp, input logic [63:0] rdata);
    burst_resp  = resp;
    burst_rdata = rdata;
    tick();
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand64(), rand64(), rand64(), rand64()};
  endfunction

  // Line-aligned address as memory must see it.
  function automatic logic [31:0] aligned(input logic [31:0] a);
    return a & ~32'h1F;
  endfunction

  // Full line read: memory returns the slices of 'line' in beat order,
  // with 'gap' idle cycles before each beat. Address is scrambled during
  // the burst to confirm it was latched.
  task automatic run_read(input logic [31:0] addr, input logic [255:0] line,
                          input int gap, input bit drop_mid);
    pmem_address = addr;
    pmem_read    = 1'b1;
    tick();
    checkOutput("rd_active", burst_read, 1);
    checkOutput("rd_no_write", burst_write, 0);
    checkOutput("rd_addr", burst_address, aligned(addr));
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        pmem_address = $urandom();
        applyStimulus(1'b0, rand64());
        checkOutput("rd_stall_active", burst_read, 1);
        checkOutput("rd_stall_resp", pmem_resp, 0);
      end
      if (drop_mid && i == 2) pmem_read = 1'b0;
      applyStimulus(1'b1, line[i*64 +: 64]);
      checkOutput("rd_addr_hold", burst_address, aligned(addr));
      if (i < 3) begin
        checkOutput("rd_mid_active", burst_read, 1);
        checkOutput("rd_mid_resp", pmem_resp, 0);
      end
    end
    burst_resp = 1'b0;
    checkOutput("rd_resp", pmem_resp, 1);
    checkOutput("rd_line", pmem_rdata, line);
    checkOutput("rd_done_idle", burst_read, 0);
    pmem_read = 1'b0;
    tick();
    checkOutput("rd_resp_once", pmem_resp, 0);
    checkOutput("rd_line_held", pmem_rdata, line);
  endtask

  // Full line write; optionally with pmem_read also high to check priority.
  task automatic run_write(input logic [31:0] addr, input logic [255:0] line,
                           input int gap, input bit with_read);
    pmem_address = addr;
    pmem_wdata   = line;
    pmem_write   = 1'b1;
    pmem_read    = with_read;
    tick();
    pmem_wdata = rand256();
    checkOutput("wr_active", burst_write, 1);
    checkOutput("wr_addr", burst_address, aligned(addr));
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, rand64());
        checkOutput("wr_stall_beat", burst_wdata, line[i*64 +: 64]);
      end
      checkOutput("wr_beat", burst_wdata, line[i*64 +: 64]);
      checkOutput("wr_no_read", burst_read, 0);
      applyStimulus(1'b1, rand64());
      if (i < 3) checkOutput("wr_mid_resp", pmem_resp, 0);
    end
    burst_resp = 1'b0;
    checkOutput("wr_drop", burst_write, 0);
    checkOutput("wr_resp", pmem_resp, 1);
    checkOutput("wr_no_read_done", burst_read, 0);
    pmem_write = 1'b0;
    pmem_read  = 1'b0;
    tick();
    checkOutput("wr_resp_once", pmem_resp, 0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_resp"}, pmem_resp, 0);
    checkOutput({tag, "_bread"}, burst_read, 0);
    checkOutput({tag, "_bwrite"}, burst_write, 0);
    checkOutput({tag, "_baddr"}, burst_address, 0);
    checkOutput({tag, "_bwdata"}, burst_wdata, 0);
    checkOutput({tag, "_rdata"}, pmem_rdata, 0);
  endtask

  initial begin
    logic [255:0] line;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    burst_rdata  = '0;
    burst_resp   = 1'b0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Spurious burst_resp in idle must not start anything.
    applyStimulus(1'b1, rand64());
    burst_resp = 1'b0;
    checkOutput("idle_resp_ignored", pmem_resp, 0);
    checkOutput("idle_no_burst", burst_read | burst_write, 0);

    // Directed read.
    line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    run_read(32'h1234_5678, line, 0, 1'b0);
    checkOutput("dir_rd_addr", burst_address, 32'h1234_5660);

    // Directed write.
    line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_write(32'hCAFE_0040, line, 0, 1'b0);

    // Stalled read, 3-cycle gaps.
    run_read(32'h0000_ABCD, rand256(), 3, 1'b0);

    // Read and write together: write first, then read on a later request.
    run_write(32'h8000_0020, rand256(), 1, 1'b1);
    run_read(32'h8000_0020, rand256(), 0, 1'b0);

    // Request dropped mid-burst still completes.
    run_read($urandom(), rand256(), 1, 1'b1);

    // Reset after beat 2 of a read.
    pmem_address = 32'h5555_5555;
    pmem_read    = 1'b1;
    tick();
    applyStimulus(1'b1, rand64());
    applyStimulus(1'b1, rand64());
    burst_resp = 1'b0;
    rst_n      = 1'b0;
    #1;
    check_all_zero("mid_reset");
    pmem_read = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, rand64());
      checkOutput("after_reset_no_resp", pmem_resp, 0);
    end
    run_read(32'h0F0F_0F0F, rand256(), 0, 1'b0);

    // Back-to-back randomized traffic.
    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(1, 0) == 1)
        run_write($urandom(), rand256(), $urandom_range(2, 0), $urandom_range(1, 0) == 1);
      else
        run_read($urandom(), rand256(), $urandom_range(2, 0), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
